median_5x5_frame_ctrl: RTL and testbench

Frame sequencer for the 5x5 median filter path. Accepts a raster pixel stream under a valid/ready handshake, tracks row/column position, and generates the per-pixel window-valid strobe that drives the median datapath's `done_i`. It also counts median results returned on the datapath's `done_o`, signals end of frame, and flags protocol faults. It sits between the pixel source / line-buffer front end and the 5x5 median filter instance.

---
 rtl/median_5x5_frame_ctrl.sv | 161 ++++++++++++++++
 tb/tb_median_5x5_frame_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/median_5x5_frame_ctrl.sv
// Frame sequencer for the 5x5 median path: pixel handshake, raster position,
// window strobe generation, result counting, end-of-frame and fault flags.
`timescale 1ns/1ps
module median_5x5_frame_ctrl #(
  parameter int unsigned ROWS     = 7,
  parameter int unsigned COLS     = 7,
  parameter int unsigned PIPE_LAT = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_i,
  input  logic                                    pix_valid_i,
  output logic                                    ready_o,
  output logic                                    win_valid_o,
  input  logic                                    median_valid_i,
  output logic [$clog2(ROWS)-1:0]                 row_o,
  output logic [$clog2(COLS)-1:0]                 col_o,
  output logic [$clog2((ROWS-4)*(COLS-4)+1)-1:0]  out_cnt_o,
  output logic                                    busy_o,
  output logic                                    frame_done_o,
  output logic                                    err_timeout_o,
  output logic                                    err_spurious_o
);

  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned N    = (ROWS - 4) * (COLS - 4);
  localparam int unsigned OW   = $clog2(N + 1);
  localparam int unsigned TOUT = PIPE_LAT + 4;
  localparam int unsigned DW   = $clog2(TOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [RW-1:0] pos_row, pos_row_nxt;
  logic [CW-1:0] pos_col, pos_col_nxt;
  logic [RW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic [OW-1:0] cnt_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          to_nxt, sp_nxt, win_nxt;
  logic          accept, in_frame, win_hit, last_pix;

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= S_IDLE;
      pos_row        <= '0;
      pos_col        <= '0;
      row_o          <= '0;
      col_o          <= '0;
      out_cnt_o      <= '0;
      drain_cnt      <= '0;
      err_timeout_o  <= 1'b0;
      err_spurious_o <= 1'b0;
      win_valid_o    <= 1'b0;
      ready_o        <= 1'b0;
      busy_o         <= 1'b0;
      frame_done_o   <= 1'b0;
    end else begin
      state          <= state_nxt;
      pos_row        <= pos_row_nxt;
      pos_col        <= pos_col_nxt;
      row_o          <= row_nxt;
      col_o          <= col_nxt;
      out_cnt_o      <= cnt_nxt;
      drain_cnt      <= drain_nxt;
      err_timeout_o  <= to_nxt;
      err_spurious_o <= sp_nxt;
      win_valid_o    <= win_nxt;
      ready_o        <= (state_nxt == S_FILL) || (state_nxt == S_RUN);
      busy_o         <= (state_nxt != S_IDLE);
      frame_done_o   <= (state_nxt == S_DONE);
    end
  end

  // Next-state, position tracking, result accounting
  always_comb begin
    state_nxt   = state;
    pos_row_nxt = pos_row;
    pos_col_nxt = pos_col;
    row_nxt     = row_o;
    col_nxt     = col_o;
    cnt_nxt     = out_cnt_o;
    drain_nxt   = drain_cnt;
    to_nxt      = err_timeout_o;
    sp_nxt      = err_spurious_o;
    win_nxt     = 1'b0;

    accept   = pix_valid_i && ready_o;
    in_frame = (state == S_FILL) || (state == S_RUN) || (state == S_DRAIN);
    win_hit  = (pos_row >= RW'(4)) && (pos_col >= CW'(4));
    last_pix = (pos_row == RW'(ROWS - 1)) && (pos_col == CW'(COLS - 1));

    // pos_* is the coordinate the next accepted pixel will carry
    if (accept) begin
      row_nxt = pos_row;
      col_nxt = pos_col;
      win_nxt = win_hit;
      if (pos_col == CW'(COLS - 1)) begin
        pos_col_nxt = '0;
        if (!last_pix) pos_row_nxt = pos_row + RW'(1);
      end else begin
        pos_col_nxt = pos_col + CW'(1);
      end
    end

    if (median_valid_i) begin
      if (in_frame && (out_cnt_o != OW'(N))) cnt_nxt = out_cnt_o + OW'(1);
      else                                   sp_nxt  = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt   = S_FILL;
          pos_row_nxt = '0;
          pos_col_nxt = '0;
          row_nxt     = '0;
          col_nxt     = '0;
          cnt_nxt     = '0;
          drain_nxt   = '0;
          to_nxt      = 1'b0;
          sp_nxt      = 1'b0;
        end
      end
      S_FILL: begin
        if (accept && last_pix) begin
          state_nxt = S_DRAIN;
          drain_nxt = '0;
        end else if (accept && win_hit) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (accept && last_pix) begin
          state_nxt = S_DRAIN;
          drain_nxt = '0;
        end
      end
      S_DRAIN: begin
        // Final result and exit share an edge; timeout only if still short
        if (cnt_nxt == OW'(N)) begin
          state_nxt = S_DONE;
        end else if (drain_cnt == DW'(TOUT - 1)) begin
          to_nxt    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          drain_nxt = drain_cnt + DW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_median_5x5_frame_ctrl.sv
// Directed bench for median_5x5_frame_ctrl: 7x7 frames with a fixed-latency
// result model, gaps, drain timeout, spurious results, mid-frame reset, restart.
`timescale 1ns/1ps
module tb_median_5x5_frame_ctrl;

  localparam int unsigned ROWS     = 7;
  localparam int unsigned COLS     = 7;
  localparam int unsigned PIPE_LAT = 8;
  localparam int          NPIX     = 49;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       pix_valid_i = 1'b0;
  logic       median_valid_i = 1'b0;
  logic       ready_o, win_valid_o, busy_o, frame_done_o;
  logic       err_timeout_o, err_spurious_o;
  logic [2:0] row_o, col_o;
  logic [3:0] out_cnt_o;

  int total = 0, bad = 0;
  int cyc = 0, wins = 0, dones = 0, pix_n = 0, res_n = 0, first_win = 0;
  int lr = 0, lc = 0, c0 = 0, drop_idx = 0;
  logic track = 1'b0, drop_en = 1'b0, dup_last = 1'b0, dup_pend = 1'b0, extra = 1'b0;
  logic [31:0] pipe = '0;

  median_5x5_frame_ctrl #(.ROWS(ROWS), .COLS(COLS), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pix_valid_i(pix_valid_i),
    .ready_o(ready_o), .win_valid_o(win_valid_o), .median_valid_i(median_valid_i),
    .row_o(row_o), .col_o(col_o), .out_cnt_o(out_cnt_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_timeout_o(err_timeout_o),
    .err_spurious_o(err_spurious_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, update model, drive result line
  task automatic tick();
    logic acc, base, dup_now;
    int r, c;
    acc = pix_valid_i && ready_o;
    r = pix_n / COLS;
    c = pix_n % COLS;
    @(posedge clk); #1;
    cyc++;
    pipe = {pipe[30:0], win_valid_o};
    if (win_valid_o) wins++;
    if (frame_done_o) dones++;
    if (track) begin
      if (acc) begin lr = r; lc = c; pix_n++; end
      chk("win", 32'(win_valid_o), 32'(acc && r >= 4 && c >= 4));
      chk("row", 32'(row_o), lr);
      chk("col", 32'(col_o), lc);
    end
    if (win_valid_o && first_win == 0) first_win = pix_n;
    dup_now  = dup_pend;
    dup_pend = 1'b0;
    base = pipe[PIPE_LAT] && !(drop_en && res_n == drop_idx);
    if (pipe[PIPE_LAT]) begin
      if (dup_last && res_n == 8) dup_pend = 1'b1;
      res_n++;
    end
    median_valid_i = base || extra || dup_now;
  endtask

  task automatic arm();
    pix_n = 0; lr = 0; lc = 0; res_n = 0; pipe = '0;
    wins = 0; dones = 0; first_win = 0; track = 1'b1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_busy", 32'(busy_o), 1);
    chk("start_rdy", 32'(ready_o), 1);
    chk("start_cnt", 32'(out_cnt_o), 0);
    chk("start_errs", 32'({err_timeout_o, err_spurious_o}), 0);
    arm();
  endtask

  task automatic feed(input bit gaps, input int stop_at, input int start_at);
    for (int g = 0; g < 600 && pix_n < stop_at; g++) begin
      pix_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i = (start_at >= 0 && pix_n == start_at);
      tick();
    end
    pix_valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (!frame_done_o && k < bound) begin tick(); k++; end
    chk("done_seen", 32'(frame_done_o), 1);
  endtask

  task automatic frame_checks(input int cnt, input bit to, input bit sp);
    chk("wins", wins, 9);
    chk("first_win", first_win, 33);
    chk("dones", dones, 1);
    chk("out_cnt", 32'(out_cnt_o), cnt);
    chk("err_to", 32'(err_timeout_o), 32'(to));
    chk("err_sp", 32'(err_spurious_o), 32'(sp));
    chk("busy_done", 32'(busy_o), 1);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick(); tick();
    chk("rst_outs", 32'({ready_o, win_valid_o, busy_o, frame_done_o, err_timeout_o,
                         err_spurious_o, row_o, col_o, out_cnt_o}), 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_o), 0);

    // Continuous 7x7 frame
    do_start();
    c0 = cyc;
    feed(1'b0, NPIX, -1);
    chk("pix_a", pix_n, NPIX);
    chk("feed_cycles", cyc - c0, 49);
    chk("rdy_fall_a", 32'(ready_o), 0);
    wait_done(40);
    frame_checks(9, 1'b0, 1'b0);
    tick();
    chk("busy_fall_a", 32'(busy_o), 0);
    chk("done_pulse_a", 32'(frame_done_o), 0);
    track = 1'b0;

    // Random source gaps
    do_start();
    feed(1'b1, NPIX, -1);
    chk("pix_b", pix_n, NPIX);
    chk("rdy_fall_b", 32'(ready_o), 0);
    wait_done(40);
    frame_checks(9, 1'b0, 1'b0);
    tick();
    track = 1'b0;

    // Drain timeout: 9th result never returns
    drop_en = 1'b1; drop_idx = 8;
    do_start();
    feed(1'b0, NPIX, -1);
    c0 = cyc;
    wait_done(40);
    chk("timeout_lat", cyc - c0, 12);
    frame_checks(8, 1'b1, 1'b0);
    drop_en = 1'b0;
    tick();
    track = 1'b0;
    chk("busy_fall_c", 32'(busy_o), 0);

    // Spurious result in IDLE, then an extra result after the 9th
    extra = 1'b1;
    tick();
    extra = 1'b0;
    tick();
    chk("sp_idle", 32'(err_spurious_o), 1);
    chk("sp_idle_cnt", 32'(out_cnt_o), 8);
    dup_last = 1'b1;
    do_start();
    feed(1'b0, NPIX, -1);
    wait_done(40);
    frame_checks(9, 1'b0, 1'b0);
    tick();
    chk("sp_extra", 32'(err_spurious_o), 1);
    chk("sp_extra_cnt", 32'(out_cnt_o), 9);
    chk("sp_dones", dones, 1);
    dup_last = 1'b0;
    track = 1'b0;
    tick();

    // Reset after 20 pixels, then a clean frame
    do_start();
    feed(1'b0, 20, -1);
    track = 1'b0;
    pix_valid_i = 1'b1;
    rst = 1'b0;
    tick();
    chk("mid_rst_outs", 32'({ready_o, win_valid_o, busy_o, frame_done_o, err_timeout_o,
                             err_spurious_o, row_o, col_o, out_cnt_o}), 0);
    rst = 1'b1;
    pix_valid_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("mid_rst_idle", 32'(busy_o), 0);
    chk("mid_rst_nodone", dones, 0);
    do_start();
    feed(1'b0, NPIX, -1);
    wait_done(40);
    frame_checks(9, 1'b0, 1'b0);
    tick();
    track = 1'b0;

    // start_i pulsed in RUN, then held across DONE for a back-to-back frame
    do_start();
    feed(1'b0, NPIX, 40);
    chk("pix_g", pix_n, NPIX);
    start_i = 1'b1;
    wait_done(40);
    frame_checks(9, 1'b0, 1'b0);
    track = 1'b0;
    tick();
    chk("gap_busy", 32'(busy_o), 0);
    chk("gap_rdy", 32'(ready_o), 0);
    tick();
    start_i = 1'b0;
    chk("b2b_busy", 32'(busy_o), 1);
    chk("b2b_rdy", 32'(ready_o), 1);
    chk("b2b_cnt", 32'(out_cnt_o), 0);
    arm();
    feed(1'b0, NPIX, -1);
    wait_done(40);
    frame_checks(9, 1'b0, 1'b0);
    tick();
    chk("busy_fall_h", 32'(busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
